// File: rtl/gpio_ctrl_apb_arbiter.sv
// -----------------------------------------------------------------------------
// gpio_ctrl_apb_arbiter
//
// Round-robin APB arbiter sharing the single APB completer port of
// gpio_ctrl_top between NUM_REQ requesters. One transfer is forwarded at a
// time: IDLE -> SETUP -> ACCESS (waits on m_pready) -> RESP -> IDLE. The
// response is returned for one cycle to the requester that owns the transfer.
//
// Parameters:
//   NUM_REQ         number of requester ports (2..8)
//   TIMEOUT_CYCLES  ACCESS-cycle limit, used only with the timeout macro
//
// Optional feature macro:
//   GPIO_CTRL_APB_ARB_TIMEOUT_EN  abort a transfer after TIMEOUT_CYCLES ACCESS
//                                 cycles with pslverr=1, prdata=0
//
// Ports:
//   clk, rst_n                 rising-edge clock, async active-low reset
//   s_psel/s_penable/s_pwrite  per-requester APB controls (NUM_REQ bits)
//   s_paddr/s_pstrb/s_pwdata   packed per-requester command fields
//   s_prdata/s_pready/s_pslverr packed per-requester responses (0 unless RESP)
//   m_*                        downstream APB requester port
// -----------------------------------------------------------------------------
module gpio_ctrl_apb_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    s_psel,
    input  logic [NUM_REQ-1:0]    s_penable,
    input  logic [NUM_REQ-1:0]    s_pwrite,
    input  logic [NUM_REQ*10-1:0] s_paddr,
    input  logic [NUM_REQ*4-1:0]  s_pstrb,
    input  logic [NUM_REQ*32-1:0] s_pwdata,
    output logic [NUM_REQ*32-1:0] s_prdata,
    output logic [NUM_REQ-1:0]    s_pready,
    output logic [NUM_REQ-1:0]    s_pslverr,
    output logic [9:0]            m_paddr,
    output logic                  m_pwrite,
    output logic                  m_psel,
    output logic                  m_penable,
    output logic [3:0]            m_pstrb,
    output logic [31:0]           m_pwdata,
    input  logic [31:0]           m_prdata,
    input  logic                  m_pready,
    input  logic                  m_pslverr
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("gpio_ctrl_apb_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, gnt_q, winner;
    logic            any_req;
    logic            timeout_hit;

    logic [9:0]      addr_q;
    logic            write_q;
    logic [3:0]      strb_q;
    logic [31:0]     wdata_q;
    logic [31:0]     rdata_q;
    logic            slverr_q;

    // s_penable is deliberately ignored: the command is sampled in IDLE only.
    logic unused_penable;
    assign unused_penable = ^s_penable;

    // Round robin: lowest requesting index at or above ptr, else lowest overall.
    // The loop runs downward so the lowest qualifying index is assigned last.
    logic [PW-1:0] winner_hi, winner_lo;
    logic          found_hi;
    // NOTE: every variable gets a default before the loop/case so no latch is inferred.
    always_comb begin
        winner_hi = '0;
        winner_lo = '0;
        found_hi  = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (s_psel[k]) begin
                winner_lo = PW'(k);
                if (PW'(k) >= ptr_q) begin
                    winner_hi = PW'(k);
                    found_hi  = 1'b1;
                end
            end
        end
        winner  = found_hi ? winner_hi : winner_lo;
        any_req = |s_psel;
    end

`ifdef GPIO_CTRL_APB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] acc_cnt_q;

    // acc_cnt_q holds the number of ACCESS cycles already completed.
    assign timeout_hit = (state_q == ST_ACCESS) && !m_pready &&
                         (acc_cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt_q <= '0;
        end else if (state_q == ST_SETUP) begin
            acc_cnt_q <= '0;
        end else if (state_q == ST_ACCESS && acc_cnt_q != CW'(TIMEOUT_CYCLES)) begin
            acc_cnt_q <= acc_cnt_q + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (any_req) state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: if (m_pready || timeout_hit) state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            gnt_q    <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            strb_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            slverr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        gnt_q   <= winner;
                        addr_q  <= s_paddr[int'(winner)*10 +: 10];
                        write_q <= s_pwrite[winner];
                        strb_q  <= s_pstrb[int'(winner)*4 +: 4];
                        wdata_q <= s_pwdata[int'(winner)*32 +: 32];
                    end
                end
                ST_ACCESS: begin
                    if (m_pready) begin
                        rdata_q  <= write_q ? '0 : m_prdata;
                        slverr_q <= m_pslverr;
                    end else if (timeout_hit) begin
                        rdata_q  <= '0;
                        slverr_q <= 1'b1;
                    end
                end
                ST_RESP: begin
                    ptr_q <= (gnt_q == PW'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Outputs are decoded from state and registers only, so reset clears them
    // asynchronously and no input reaches an output combinationally.
    logic xfer;
    assign xfer      = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign m_psel    = xfer;
    assign m_penable = (state_q == ST_ACCESS);
    assign m_paddr   = xfer ? addr_q  : '0;
    assign m_pwrite  = xfer ? write_q : 1'b0;
    assign m_pstrb   = xfer ? strb_q  : '0;
    assign m_pwdata  = xfer ? wdata_q : '0;

    always_comb begin
        s_pready  = '0;
        s_pslverr = '0;
        s_prdata  = '0;
        if (state_q == ST_RESP) begin
            s_pready[gnt_q]                 = 1'b1;
            s_pslverr[gnt_q]                = slverr_q;
            s_prdata[int'(gnt_q)*32 +: 32]  = rdata_q;
        end
    end

endmodule

// File: tb/tb_gpio_ctrl_apb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_gpio_ctrl_apb_arbiter
//
// Scoreboard bench for gpio_ctrl_apb_arbiter with NUM_REQ=3. Requesters push
// their expected response when they issue a command; a monitor checks grants
// against a round-robin model and pops responses when s_pready appears. The
// downstream completer answers reads with a function of the address, flags
// addresses 0x300-0x3FF as errors and inserts programmable wait states.
// -----------------------------------------------------------------------------
module tb_gpio_ctrl_apb_arbiter;

    localparam int N  = 3;
    localparam int TO = 8;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    s_psel, s_penable, s_pwrite;
    logic [N*10-1:0] s_paddr;
    logic [N*4-1:0]  s_pstrb;
    logic [N*32-1:0] s_pwdata;
    logic [N*32-1:0] s_prdata;
    logic [N-1:0]    s_pready, s_pslverr;
    logic [9:0]      m_paddr;
    logic            m_pwrite, m_psel, m_penable;
    logic [3:0]      m_pstrb;
    logic [31:0]     m_pwdata, m_prdata;
    logic            m_pready, m_pslverr;

    gpio_ctrl_apb_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
        .s_paddr(s_paddr), .s_pstrb(s_pstrb), .s_pwdata(s_pwdata),
        .s_prdata(s_prdata), .s_pready(s_pready), .s_pslverr(s_pslverr),
        .m_paddr(m_paddr), .m_pwrite(m_pwrite), .m_psel(m_psel),
        .m_penable(m_penable), .m_pstrb(m_pstrb), .m_pwdata(m_pwdata),
        .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- completer model ----------------
    bit          hang = 1'b0;
    int          fixed_waits = 0;
    bit          force_rd_en = 1'b0;
    logic [31:0] force_rd_val = '0;
    int          left = 0;

    function automatic logic [31:0] read_value(input logic [9:0] a);
        return {6'h15, a, ~a, 6'h2A};
    endfunction

    function automatic logic err_of(input logic [9:0] a);
        return a[9:8] == 2'b11;
    endfunction

    always @(negedge clk) begin
        m_pready  = 1'b0;
        m_pslverr = 1'b0;
        m_prdata  = $urandom;
        if (!rst_n) begin
            left = 0;
        end else if (m_psel && !m_penable) begin
            left = (fixed_waits >= 0) ? fixed_waits : int'($urandom_range(0, 3));
        end else if (m_psel && m_penable && !hang) begin
            if (left == 0) begin
                m_pready  = 1'b1;
                m_pslverr = err_of(m_paddr);
                if (!m_pwrite)
                    m_prdata = force_rd_en ? force_rd_val : read_value(m_paddr);
            end else begin
                left--;
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int          id;
        logic [31:0] rdata;
        logic        slverr;
        int          issue_cyc;
        int          exp_lat;
    } exp_t;

    exp_t        exp_q[$];
    int          grant_log[$];
    int          cyc = 0;
    int          mptr = 0;
    int          last_ready = -1;
    bit          chk_gap = 1'b0;
    logic [N-1:0] snap;

    logic [9:0]  cmd_addr  [N];
    logic        cmd_write [N];
    logic [3:0]  cmd_strb  [N];
    logic [31:0] cmd_wdata [N];
    logic [N-1:0] busy;

    always @(posedge clk) begin
        cyc++;
        snap = s_psel;
    end

    int  w, hit, kk;
    bit  lanes_ok;
    always @(negedge clk) begin
        if (rst_n) begin
            lanes_ok = 1'b1;
            for (int j = 0; j < N; j++)
                if (!s_pready[j] && (s_prdata[j*32 +: 32] != 0 || s_pslverr[j])) lanes_ok = 1'b0;
            check("idle_lanes_zero", lanes_ok, 1);

            if (m_psel && !m_penable) begin
                w = -1;
                for (int off = 0; off < N; off++) begin
                    kk = (mptr + off) % N;
                    if (w < 0 && snap[kk]) w = kk;
                end
                check("grant_has_request", w >= 0, 1);
                if (w >= 0) begin
                    check("grant_addr", m_paddr, cmd_addr[w]);
                    check("grant_write", m_pwrite, cmd_write[w]);
                    check("grant_strb", m_pstrb, cmd_strb[w]);
                    check("grant_wdata", m_pwdata, cmd_wdata[w]);
                    grant_log.push_back(w);
                    mptr = (w + 1) % N;
                end
            end

            if (s_pready != 0) begin
                check("pready_onehot", $countones(s_pready), 1);
                check("m_psel_low_in_resp", m_psel, 0);
                for (int j = 0; j < N; j++) begin
                    if (s_pready[j]) begin
                        hit = -1;
                        for (int q = 0; q < exp_q.size(); q++)
                            if (hit < 0 && exp_q[q].id == j) hit = q;
                        check("resp_expected", hit >= 0, 1);
                        if (hit >= 0) begin
                            check("resp_rdata", s_prdata[j*32 +: 32], exp_q[hit].rdata);
                            check("resp_slverr", s_pslverr[j], exp_q[hit].slverr);
                            if (exp_q[hit].exp_lat >= 0)
                                check("resp_latency", cyc - exp_q[hit].issue_cyc, exp_q[hit].exp_lat);
                            exp_q.delete(hit);
                        end
                    end
                end
                if (chk_gap && last_ready >= 0)
                    check("resp_spacing", cyc - last_ready, 4);
                last_ready = cyc;
            end
        end
    end

    // ---------------- requester driver ----------------
    task automatic issue(input int i, input bit wr, input logic [9:0] a,
                         input logic [31:0] d, input logic [3:0] st, input int lat);
        exp_t e;
        s_psel[i]           = 1'b1;
        s_penable[i]        = 1'b0;
        s_pwrite[i]         = wr;
        s_paddr[i*10 +: 10] = a;
        s_pstrb[i*4 +: 4]   = st;
        s_pwdata[i*32 +: 32] = d;
        cmd_addr[i]  = a;
        cmd_write[i] = wr;
        cmd_strb[i]  = st;
        cmd_wdata[i] = d;
        busy[i]      = 1'b1;
        e.id        = i;
        e.slverr    = hang ? 1'b1 : err_of(a);
        e.rdata     = (hang || wr) ? 32'h0 : (force_rd_en ? force_rd_val : read_value(a));
        e.issue_cyc = cyc;
        e.exp_lat   = lat;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (busy[i] && s_pready[i]) begin
                busy[i]      = 1'b0;
                s_psel[i]    = 1'b0;
                s_penable[i] = 1'b0;
            end else if (busy[i]) begin
                s_penable[i] = 1'b1;
            end
        end
    endtask

    task automatic clear_requesters();
        s_psel = '0; s_penable = '0; busy = '0;
        exp_q.delete();
        mptr = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_requesters();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (busy != 0 && n < budget) begin
            step();
            n++;
        end
        check("done_within_budget", busy == 0, 1);
        if (busy != 0) do_reset();
        else step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int n;
    initial begin
        rst_n = 1'b1;
        s_psel = '0; s_penable = '0; s_pwrite = '0;
        s_paddr = '0; s_pstrb = '0; s_pwdata = '0;
        busy = '0;
        for (int i = 0; i < N; i++) begin
            cmd_addr[i] = '0; cmd_write[i] = 1'b0; cmd_strb[i] = '0; cmd_wdata[i] = '0;
        end
        #1 rst_n = 1'b0;
        #1;
        check("rst_m_psel", m_psel, 0);
        check("rst_m_penable", m_penable, 0);
        check("rst_s_pready", s_pready, 0);
        check("rst_m_paddr", m_paddr, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step();

        // single write, zero wait: pready 3 cycles after the request
        fixed_waits = 0;
        issue(0, 1'b1, 10'h004, 32'hA5A5_0001, 4'hF, 3);
        wait_done(20);

        // ptr now 1: simultaneous 0 and 1 requests must grant 1 first
        grant_log.delete();
        issue(0, 1'b1, 10'h008, 32'h1111_0000, 4'h3, -1);
        issue(1, 1'b1, 10'h00C, 32'h2222_0000, 4'hC, -1);
        wait_done(30);
        check("ptr_after_single", grant_log.size() >= 2 ? grant_log[0] : -1, 1);
        check("ptr_second_grant", grant_log.size() >= 2 ? grant_log[1] : -1, 0);

        // read with 3 wait states returning a fixed word on lane 1
        fixed_waits  = 3;
        force_rd_en  = 1'b1;
        force_rd_val = 32'h1234_5678;
        issue(1, 1'b0, 10'h010, 32'h0, 4'h0, 6);
        wait_done(30);
        force_rd_en = 1'b0;

        // error pass-through on a write, followed by a normal transfer
        fixed_waits = 1;
        issue(2, 1'b1, 10'h3F0, 32'hDEAD_BEEF, 4'hF, 4);
        wait_done(30);
        fixed_waits = 0;
        issue(2, 1'b0, 10'h044, 32'h0, 4'h0, 3);
        wait_done(20);

        // contention from reset: all requesters keep requesting
        do_reset();
        grant_log.delete();
        chk_gap    = 1'b1;
        last_ready = -1;
        for (int i = 0; i < N; i++) issue(i, 1'b0, 10'(10'h100 + i * 4), 32'h0, 4'h0, -1);
        n = 0;
        while (grant_log.size() < 6 && n < 60) begin
            step();
            for (int i = 0; i < N; i++)
                if (!busy[i]) issue(i, 1'b1, 10'(10'h100 + i * 4), $urandom, 4'hF, -1);
            n++;
        end
        wait_done(40);
        chk_gap = 1'b0;
        check("contention_grants", grant_log.size() >= 6, 1);
        for (int g = 0; g < 6; g++)
            check("contention_order", g < grant_log.size() ? grant_log[g] : -1, g % N);

        // reset in the middle of ACCESS; ptr is 1 beforehand
        issue(0, 1'b1, 10'h020, 32'h0BAD_F00D, 4'hF, 3);
        wait_done(20);
        hang = 1'b1;
        issue(1, 1'b0, 10'h024, 32'h0, 4'h0, -1);
        n = 0;
        while (!m_penable && n < 10) begin
            step();
            n++;
        end
        check("reached_access", m_penable, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_m_psel", m_psel, 0);
        check("async_rst_m_penable", m_penable, 0);
        check("async_rst_m_paddr", m_paddr, 0);
        check("async_rst_s_pready", s_pready, 0);
        clear_requesters();
        hang = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        grant_log.delete();
        for (int i = 0; i < N; i++) issue(i, 1'b0, 10'(10'h200 + i * 8), 32'h0, 4'h0, -1);
        wait_done(40);
        check("first_grant_after_reset", grant_log.size() > 0 ? grant_log[0] : -1, 0);

`ifdef GPIO_CTRL_APB_ARB_TIMEOUT_EN
        // downstream never ready: abort after TO ACCESS cycles
        hang = 1'b1;
        issue(2, 1'b0, 10'h030, 32'h0, 4'h0, TO + 2);
        wait_done(40);
        hang = 1'b0;
`endif

        // randomized traffic with random wait states
        fixed_waits = -1;
        for (int c = 0; c < 2000; c++) begin
            step();
            for (int i = 0; i < N; i++)
                if (!busy[i] && $urandom_range(0, 3) == 0)
                    issue(i, 1'($urandom_range(0, 1)), 10'($urandom), $urandom, 4'($urandom), -1);
        end
        wait_done(200);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gpio_ctrl_apb_arbiter.md
# gpio_ctrl_apb_arbiter

Round-robin APB arbiter that shares the GPIO controller's single APB completer port between NUM_REQ APB requesters, for example a CPU and a GPIO pattern sequencer. Each requester sees an APB completer port. The block forwards one transfer at a time to the downstream `gpio_ctrl_top` APB port and returns the response to the requester that owns the transfer. It sits between the system interconnect and `gpio_ctrl_top`.

## Interface
Parameters:
- NUM_REQ, default 2: number of requester ports, 2..8.
- TIMEOUT_CYCLES, default 255: maximum ACCESS cycles before an abort. Used only when the timeout macro is defined.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- s_psel  in  NUM_REQ  per-requester psel.
- s_penable  in  NUM_REQ  per-requester penable.
- s_pwrite  in  NUM_REQ  per-requester pwrite.
- s_paddr  in  NUM_REQ*10  packed addresses; requester i uses bits [i*10 +: 10].
- s_pstrb  in  NUM_REQ*4  packed write strobes.
- s_pwdata  in  NUM_REQ*32  packed write data.
- s_prdata  out  NUM_REQ*32  packed read data; valid only while that requester's s_pready is high, otherwise 0.
- s_pready  out  NUM_REQ  per-requester pready.
- s_pslverr  out  NUM_REQ  per-requester pslverr; valid with s_pready, otherwise 0.
- m_paddr  out  10  downstream address.
- m_pwrite  out  1  downstream write.
- m_psel  out  1  downstream select.
- m_penable  out  1  downstream enable.
- m_pstrb  out  4  downstream write strobes.
- m_pwdata  out  32  downstream write data.
- m_prdata  in  32  downstream read data.
- m_pready  in  1  downstream ready.
- m_pslverr  in  1  downstream error.

## Operation
FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - If any s_psel bit is high, pick winner g by round-robin starting at pointer ptr.
  - On the clock edge, register g, s_paddr, s_pwrite, s_pstrb and s_pwdata of g, then go to SETUP.
  - If no s_psel bit is high, stay in IDLE.
- SETUP:
  - m_psel=1, m_penable=0, m_* driven from the registered command.
  - Always goes to ACCESS next.
- ACCESS:
  - m_psel=1, m_penable=1.
  - Stays in ACCESS while m_pready=0.
  - When m_pready=1, capture m_prdata (0 for writes) and m_pslverr, then go to RESP.
- RESP:
  - s_pready[g]=1, with s_prdata[g] and s_pslverr[g] from the captured values, for exactly one cycle.
  - ptr <= (g+1) mod NUM_REQ.
  - Go to IDLE.
- Outside SETUP and ACCESS, all m_* outputs are 0.
- s_pready is 0 for every requester except g in RESP. Non-granted requesters are stalled by their low s_pready.
- Command fields are sampled only in IDLE. A requester's s_penable is not checked; the registered command must stay stable for the transfer per APB rules.
- If the granted requester drops s_psel mid-transfer (protocol violation), the downstream transfer still completes and RESP still pulses. The response is lost.
- Simultaneous requests: the first set bit at or after ptr, wrapping modulo NUM_REQ, wins. A requester therefore waits at most NUM_REQ-1 transfers.
- Reset (asynchronous, any state): FSM goes to IDLE, ptr=0, all outputs 0, including mid-ACCESS. The downstream transfer is abandoned; the downstream side is assumed to be reset by the same rst_n.

## Timing
- With a zero-wait downstream, a request seen in IDLE at cycle 0 gives SETUP at cycle 1, ACCESS at cycle 2, s_pready at cycle 3 and IDLE at cycle 4.
- Minimum request-to-pready latency is 3 cycles. Each downstream wait state adds 1 cycle.
- Sustained throughput is one transfer per 4 cycles.
- All outputs are registered or decoded from FSM state only. There is no combinational path from any s_* input or m_pready to any output.

## Configuration
- GPIO_CTRL_APB_ARB_TIMEOUT_EN defined:
  - An ACCESS-cycle counter is cleared on entry to SETUP.
  - If m_pready is still low after TIMEOUT_CYCLES ACCESS cycles, the FSM goes to RESP with captured prdata=0 and pslverr=1, and the downstream m_psel and m_penable drop to 0.
  - The counter is wide enough to hold TIMEOUT_CYCLES.
- GPIO_CTRL_APB_ARB_TIMEOUT_EN not defined:
  - No counter is built.
  - ACCESS waits for m_pready indefinitely.

## Test plan
- Single write: requester 0 writes 0xA5A5_0001 to 0x004, zero-wait downstream. Required: m_psel at cycle 1, m_penable at cycle 2, s_pready[0] at cycle 3, s_pslverr[0]=0, ptr=1.
- Read with 3 wait states: downstream returns 0x1234_5678. Required: s_pready[1] 6 cycles after the request, s_prdata[1]=0x1234_5678, other s_prdata lanes 0.
- Contention: NUM_REQ=3, all requesters assert s_psel continuously from reset. Required: grant order 0,1,2,0,1,2; each s_pready 4 cycles apart; no requester starved.
- Error pass-through: downstream returns m_pslverr=1 on a write. Required: s_pslverr[g]=1 in the same cycle as s_pready[g]; FSM returns to IDLE.
- Reset mid-ACCESS: assert rst_n=0 while the FSM is in ACCESS. Required: all outputs 0 immediately (asynchronously); after release, the first grant goes to requester 0.
- Timeout (macro defined, TIMEOUT_CYCLES=8): m_pready held at 0. Required: after 8 ACCESS cycles, m_psel=0, then s_pready[g]=1, s_pslverr[g]=1, s_prdata[g]=0.
